sprite_linebuf: RTL and testbench

Double-buffered 256-pixel scanline buffer that sits directly downstream of the video timing generator. It consumes hcount/vcount/hb/vb and scans one buffer out to the colour stage while the sprite renderer fills the other buffer with the next line. Each front-buffer pixel is cleared as it is read, so the buffer is empty when it becomes the back buffer again. A post-reset clear pass guarantees that no stale RAM content reaches the screen.

---
 rtl/sprite_linebuf.sv | 174 +++++++++++++++++
 tb/tb_sprite_linebuf.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_linebuf.sv
// Double-buffered scanline buffer: scans the front bank out to the colour stage
// while the sprite renderer fills the back bank; front pixels are erased as they are read.
module sprite_linebuf #(
    parameter int PIXW    = 8,
    parameter int HLAST   = 442,
    parameter int HACTIVE = 256,
    parameter int VLAST   = 262
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [8:0]      hcount,
    input  logic [8:0]      vcount,
    input  logic            hb,
    input  logic            vb,
    input  logic            wr_en,
    input  logic [7:0]      wr_x,
    input  logic [PIXW-1:0] wr_pix,
    output logic            line_start,
    output logic [8:0]      render_line,
    output logic            ready,
    output logic [PIXW-1:0] pix_out
);

    localparam logic [8:0] HLAST_V   = 9'(HLAST);
    localparam logic [8:0] HACT_V    = 9'(HACTIVE);
    localparam logic [8:0] VLAST_V   = 9'(VLAST);
    localparam logic [8:0] CLR_LAST  = 9'(2 * HACTIVE - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t state, state_next;

    logic [8:0]      clr_cnt;
    logic            bank_sel;
    logic            scrub_valid;
    logic [7:0]      scrub_addr;
    logic            scrub_bank;
    logic [8:0]      render_next;

    logic [PIXW-1:0] bank0 [HACTIVE];
    logic [PIXW-1:0] bank1 [HACTIVE];

    logic            we0, we1;
    logic [7:0]      addr0, addr1;
    logic [PIXW-1:0] wd0, wd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // bit 8 of the clear counter picks the bank, bits 7:0 the pixel
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 9'd1;
        end
    end

    // The line after next, wrapping at the frame end
    always_comb begin
        if (vcount >= VLAST_V - 9'd1) begin
            render_next = vcount - (VLAST_V - 9'd1);
        end else begin
            render_next = vcount + 9'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_sel    <= 1'b0;
            line_start  <= 1'b0;
            render_line <= '0;
            scrub_valid <= 1'b0;
            scrub_addr  <= '0;
            scrub_bank  <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            scrub_valid <= (state == RUN) && (hcount < HACT_V);
            scrub_addr  <= hcount[7:0];
            scrub_bank  <= bank_sel;
            if ((state == RUN) && (hcount == HLAST_V)) begin
                bank_sel    <= ~bank_sel;
                line_start  <= 1'b1;
                render_line <= render_next;
            end
        end
    end

    // Each bank has one write port; in RUN the scrub and the renderer always hit opposite banks
    always_comb begin
        we0   = 1'b0;
        we1   = 1'b0;
        addr0 = '0;
        addr1 = '0;
        wd0   = '0;
        wd1   = '0;
        if (state == CLEAR) begin
            if (clr_cnt[8]) begin
                we1   = 1'b1;
                addr1 = clr_cnt[7:0];
            end else begin
                we0   = 1'b1;
                addr0 = clr_cnt[7:0];
            end
        end else begin
            if (scrub_valid) begin
                if (scrub_bank) begin
                    we1   = 1'b1;
                    addr1 = scrub_addr;
                end else begin
                    we0   = 1'b1;
                    addr0 = scrub_addr;
                end
            end
            if (wr_en && (wr_pix != '0)) begin
                if (bank_sel) begin
                    we0   = 1'b1;
                    addr0 = wr_x;
                    wd0   = wr_pix;
                end else begin
                    we1   = 1'b1;
                    addr1 = wr_x;
                    wd1   = wr_pix;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we0) begin
            bank0[addr0] <= wd0;
        end
        if (we1) begin
            bank1[addr1] <= wd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_out <= '0;
        end else if ((state == RUN) && !hb && !vb && (hcount < HACT_V)) begin
            pix_out <= bank_sel ? bank1[hcount[7:0]] : bank0[hcount[7:0]];
        end else begin
            pix_out <= '0;
        end
    end

endmodule

// File: tb/tb_sprite_linebuf.sv
// Directed bench for sprite_linebuf: acts as the timing generator and renderer,
// checking every scanned pixel, line_start pulse and render_line against hand-derived values.
module tb_sprite_linebuf;

    localparam int HLAST = 442;
    localparam int VLAST = 262;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       hb;
    logic       vb;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [7:0] wr_pix;
    logic       line_start;
    logic [8:0] render_line;
    logic       ready;
    logic [7:0] pix_out;

    int n_vec = 0;
    int n_bad = 0;
    int cur_h = 0;
    int cur_v = 0;

    logic [7:0] exp_line [256];

    typedef struct {
        int         h;
        logic [7:0] x;
        logic [7:0] p;
    } wr_t;

    wr_t wq[$];

    // Three renderer writes to the same x at hcount h0, h0+1, h0+2 (dropped past HLAST)
    typedef struct {
        int         h0;
        logic [7:0] x;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
        logic [7:0] exp_pix;
    } vec_t;

    vec_t vecs [8];

    sprite_linebuf #(
        .PIXW   (8),
        .HLAST  (442),
        .HACTIVE(256),
        .VLAST  (262)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hcount     (hcount),
        .vcount     (vcount),
        .hb         (hb),
        .vb         (vb),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_pix     (wr_pix),
        .line_start (line_start),
        .render_line(render_line),
        .ready      (ready),
        .pix_out    (pix_out)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input int h, input int v, input logic vbl, input logic rst_n,
                                 input logic we, input logic [7:0] x, input logic [7:0] p);
        reset_n = rst_n;
        hcount  = 9'(h);
        vcount  = 9'(v);
        hb      = (h >= 256);
        vb      = vbl;
        wr_en   = we;
        wr_x    = x;
        wr_pix  = p;
        cur_h   = h;
        cur_v   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s at v=%0d h=%0d: got %0h, want %0h", name, cur_v, cur_h, actual, expected);
        end
    endtask

    function automatic void clear_exp();
        foreach (exp_line[i]) exp_line[i] = 8'h00;
    endfunction

    task automatic add_write(input int h, input logic [7:0] x, input logic [7:0] p);
        wr_t w;
        if (h <= HLAST) begin
            w.h = h;
            w.x = x;
            w.p = p;
            wq.push_back(w);
        end
    endtask

    task automatic run_line(input int v, input logic vbl, input int stop_h);
        for (int h = 0; h < stop_h; h++) begin
            logic       we;
            logic [7:0] x;
            logic [7:0] p;
            we = 1'b0;
            x  = 8'h00;
            p  = 8'h00;
            foreach (wq[i]) begin
                if (wq[i].h == h) begin
                    we = 1'b1;
                    x  = wq[i].x;
                    p  = wq[i].p;
                end
            end
            applyStimulus(h, v, vbl, 1'b1, we, x, p);
            checkOutput("pix_out", int'(pix_out), (h < 256 && !vbl) ? int'(exp_line[h]) : 0);
            checkOutput("line_start", int'(line_start), (h == HLAST) ? 1 : 0);
            if (h == HLAST) checkOutput("render_line", int'(render_line), (v + 2) % (VLAST + 1));
            if (h == 0) checkOutput("ready", int'(ready), 1);
        end
        wq.delete();
    endtask

    // Renderer keeps writing during CLEAR and hcount sits on HLAST: neither may have any effect
    task automatic do_reset(input int v, input int h, input int hold);
        int low;
        int guard;
        for (int i = 0; i < hold; i++) applyStimulus(h, v, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("reset_pix_out", int'(pix_out), 0);
        checkOutput("reset_line_start", int'(line_start), 0);
        checkOutput("reset_render_line", int'(render_line), 0);
        checkOutput("reset_ready", int'(ready), 0);
        low   = 1;
        guard = 0;
        while (!ready && guard < 1000) begin
            applyStimulus(HLAST, 0, 1'b1, 1'b1, 1'b1, 8'd33, 8'hEE);
            checkOutput("clear_line_start", int'(line_start), 0);
            checkOutput("clear_pix_out", int'(pix_out), 0);
            if (!ready) low++;
            guard++;
        end
        checkOutput("clear_cycles", low, 512);
    endtask

    initial begin
        vecs[0] = '{40,  8'd5,   8'h3C, 8'h00, 8'h00, 8'h3C};
        vecs[1] = '{300, 8'd20,  8'h11, 8'h00, 8'h22, 8'h22};
        vecs[2] = '{300, 8'd20,  8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{10,  8'd0,   8'h7F, 8'h00, 8'h00, 8'h7F};
        vecs[4] = '{100, 8'd128, 8'h01, 8'h02, 8'h03, 8'h03};
        vecs[5] = '{442, 8'd255, 8'h5A, 8'h00, 8'h00, 8'h5A};
        vecs[6] = '{440, 8'd255, 8'h00, 8'hC3, 8'h00, 8'hC3};
        vecs[7] = '{200, 8'd77,  8'h00, 8'hAA, 8'h00, 8'hAA};

        do_reset(0, 0, 3);
        clear_exp();
        run_line(8, 1'b0, 443);

        // Each line shows the previous vector's pixel while rendering the current one
        for (int i = 0; i < 8; i++) begin
            clear_exp();
            if (i > 0) exp_line[vecs[i-1].x] = vecs[i-1].exp_pix;
            add_write(vecs[i].h0,     vecs[i].x, vecs[i].p0);
            add_write(vecs[i].h0 + 1, vecs[i].x, vecs[i].p1);
            add_write(vecs[i].h0 + 2, vecs[i].x, vecs[i].p2);
            run_line(9 + i, 1'b0, 443);
        end
        clear_exp();
        exp_line[vecs[7].x] = vecs[7].exp_pix;
        run_line(17, 1'b0, 443);
        clear_exp();
        run_line(18, 1'b0, 443);

        // Pixels rendered for a blanked line never show and are gone when that bank returns
        clear_exp();
        add_write(40, 8'd30, 8'h99);
        add_write(41, 8'd31, 8'h98);
        add_write(300, 8'd200, 8'h97);
        run_line(223, 1'b0, 443);
        run_line(224, 1'b1, 443);
        run_line(225, 1'b1, 443);
        run_line(260, 1'b1, 443);
        run_line(261, 1'b1, 443);
        run_line(262, 1'b1, 443);
        run_line(0, 1'b0, 443);
        run_line(1, 1'b0, 443);

        // Dirty both banks, then reset in the middle of a visible line
        add_write(300, 8'd100, 8'hA5);
        add_write(301, 8'd200, 8'hB6);
        add_write(302, 8'd250, 8'hC7);
        run_line(2, 1'b0, 443);
        clear_exp();
        exp_line[100] = 8'hA5;
        exp_line[200] = 8'hB6;
        exp_line[250] = 8'hC7;
        add_write(40, 8'd150, 8'hD8);
        add_write(41, 8'd220, 8'hE9);
        run_line(3, 1'b0, 100);
        do_reset(3, 100, 1);
        clear_exp();
        run_line(4, 1'b0, 443);
        run_line(5, 1'b0, 443);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
